// File: rtl/comet2_pkg.sv
// comet2_pkg: COMET II opcode constants, fetch FSM states and the
// instruction-length rule shared by the fetch and decode stages.
package comet2_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LD     = 8'h10;
  localparam logic [7:0] OP_ST     = 8'h11;
  localparam logic [7:0] OP_LAD    = 8'h12;
  localparam logic [7:0] OP_LD_R   = 8'h14;
  localparam logic [7:0] OP_ADDA   = 8'h20;
  localparam logic [7:0] OP_SUBA   = 8'h21;
  localparam logic [7:0] OP_ADDL   = 8'h22;
  localparam logic [7:0] OP_SUBL   = 8'h23;
  localparam logic [7:0] OP_ADDA_R = 8'h24;
  localparam logic [7:0] OP_SUBA_R = 8'h25;
  localparam logic [7:0] OP_ADDL_R = 8'h26;
  localparam logic [7:0] OP_SUBL_R = 8'h27;
  localparam logic [7:0] OP_AND    = 8'h30;
  localparam logic [7:0] OP_OR     = 8'h31;
  localparam logic [7:0] OP_XOR    = 8'h32;
  localparam logic [7:0] OP_AND_R  = 8'h34;
  localparam logic [7:0] OP_OR_R   = 8'h35;
  localparam logic [7:0] OP_XOR_R  = 8'h36;
  localparam logic [7:0] OP_CPA    = 8'h40;
  localparam logic [7:0] OP_CPL    = 8'h41;
  localparam logic [7:0] OP_CPA_R  = 8'h44;
  localparam logic [7:0] OP_CPL_R  = 8'h45;
  localparam logic [7:0] OP_SLA    = 8'h50;
  localparam logic [7:0] OP_SRA    = 8'h51;
  localparam logic [7:0] OP_SLL    = 8'h52;
  localparam logic [7:0] OP_SRL    = 8'h53;
  localparam logic [7:0] OP_JMI    = 8'h61;
  localparam logic [7:0] OP_JNZ    = 8'h62;
  localparam logic [7:0] OP_JZE    = 8'h63;
  localparam logic [7:0] OP_JUMP   = 8'h64;
  localparam logic [7:0] OP_JPL    = 8'h65;
  localparam logic [7:0] OP_JOV    = 8'h66;
  localparam logic [7:0] OP_PUSH   = 8'h70;
  localparam logic [7:0] OP_POP    = 8'h71;
  localparam logic [7:0] OP_CALL   = 8'h80;
  localparam logic [7:0] OP_RET    = 8'h81;
  localparam logic [7:0] OP_SVC    = 8'hF0;

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    HOLD   = 2'd2
  } fetch_state_e;

  // Register-to-register ALU/compare forms (high nibble 1..4 with bit 2 set),
  // NOP, POP and RET are one word; every other opcode, defined or not,
  // carries an adr word.
  function automatic logic is_two_word(input logic [7:0] op);
    logic one_word;
    one_word = (op == OP_NOP) || (op == OP_POP) || (op == OP_RET) ||
               ((op[7:4] >= 4'd1) && (op[7:4] <= 4'd4) && op[2]);
    return !one_word;
  endfunction

endpackage

// File: rtl/comet2_inst_len.sv
// comet2_inst_len: classifies an opcode word as one- or two-word.
module comet2_inst_len
  import comet2_pkg::*;
(
  input  logic [15:0] i_word1,
  output logic        o_len2
);

  // Register fields never influence the length; folded away explicitly.
  logic w_unused_reg_fields;

  assign w_unused_reg_fields = ^i_word1[7:0];
  assign o_len2              = is_two_word(i_word1[15:8]);

endmodule

// File: rtl/comet2_fetch_unit.sv
// comet2_fetch_unit: COMET II instruction fetch. Reads program RAM from the
// PC, assembles one/two-word instructions and holds each one for decode.
module comet2_fetch_unit
  import comet2_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic        re,
  output logic [15:0] raddr,
  input  logic [15:0] rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_word1,
  output logic [15:0] inst_word2,
  output logic        inst_len2,
  output logic [15:0] inst_pc
);

  fetch_state_e r_state, w_state_nxt;
  logic [15:0]  r_pc, w_pc_nxt;
  logic [15:0]  r_stage_word1, w_stage_word1_nxt;
  logic [15:0]  r_stage_pc, w_stage_pc_nxt;
  logic         r_valid, w_valid_nxt;
  logic [15:0]  r_word1, w_word1_nxt;
  logic [15:0]  r_word2, w_word2_nxt;
  logic         r_len2, w_len2_nxt;
  logic [15:0]  r_inst_pc, w_inst_pc_nxt;
  logic         w_rdata_len2;
  logic         w_re;

  comet2_inst_len u_inst_len (
    .i_word1 (rdata),
    .o_len2  (w_rdata_len2)
  );

  // Read strobe: only in fetch cycles, and quiet while reset is held.
  always_comb begin
    w_re = 1'b0;
    if (rst) begin
      w_re = 1'b0;
    end else if (r_state == FETCH2) begin
      w_re = 1'b1;
    end else if (r_state == FETCH1) begin
      w_re = fetch_en;
    end else begin
      w_re = 1'b0;
    end
  end

  assign re    = w_re;
  assign raddr = w_re ? r_pc : 16'h0000;

  // Next state; a redirect overrides every other transition. A two-word
  // opcode waits in the stage registers so decode outputs only move on
  // the edge that enters HOLD.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_stage_word1_nxt = r_stage_word1;
    w_stage_pc_nxt    = r_stage_pc;
    w_valid_nxt       = r_valid;
    w_word1_nxt       = r_word1;
    w_word2_nxt       = r_word2;
    w_len2_nxt        = r_len2;
    w_inst_pc_nxt     = r_inst_pc;
    if (pc_load) begin
      w_state_nxt = FETCH1;
      w_pc_nxt    = pc_load_value;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        FETCH1: begin
          if (fetch_en) begin
            w_pc_nxt = r_pc + 16'd1;
            if (w_rdata_len2) begin
              w_stage_word1_nxt = rdata;
              w_stage_pc_nxt    = r_pc;
              w_state_nxt       = FETCH2;
            end else begin
              w_word1_nxt   = rdata;
              w_word2_nxt   = 16'h0000;
              w_len2_nxt    = 1'b0;
              w_inst_pc_nxt = r_pc;
              w_valid_nxt   = 1'b1;
              w_state_nxt   = HOLD;
            end
          end else begin
            w_state_nxt = FETCH1;
          end
        end
        FETCH2: begin
          w_pc_nxt      = r_pc + 16'd1;
          w_word1_nxt   = r_stage_word1;
          w_word2_nxt   = rdata;
          w_len2_nxt    = 1'b1;
          w_inst_pc_nxt = r_stage_pc;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = HOLD;
        end
        HOLD: begin
          if (inst_ready) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = FETCH1;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        default: begin
          w_valid_nxt = 1'b0;
          w_state_nxt = FETCH1;
        end
      endcase
    end
  end

  // State, PC and instruction registers.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH1;
      r_pc          <= RESET_PC;
      r_stage_word1 <= 16'h0000;
      r_stage_pc    <= 16'h0000;
      r_valid       <= 1'b0;
      r_word1       <= 16'h0000;
      r_word2       <= 16'h0000;
      r_len2        <= 1'b0;
      r_inst_pc     <= 16'h0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_stage_word1 <= w_stage_word1_nxt;
      r_stage_pc    <= w_stage_pc_nxt;
      r_valid       <= w_valid_nxt;
      r_word1       <= w_word1_nxt;
      r_word2       <= w_word2_nxt;
      r_len2        <= w_len2_nxt;
      r_inst_pc     <= w_inst_pc_nxt;
    end
  end

  assign inst_valid = r_valid;
  assign inst_word1 = r_word1;
  assign inst_word2 = r_word2;
  assign inst_len2  = r_len2;
  assign inst_pc    = r_inst_pc;

endmodule
